tl_ul_master_engine: RTL and testbench

//  Synthesizable, parametrised TileLink-UL master engine; successor to the single-ID behavioral tile master.

---
 rtl/tl_ul_master_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_tl_ul_master_engine.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_master_engine.sv
// TileLink-UL master engine: command stream in, A-channel requests out, D-channel beats back as responses.
// Optional per-ID response timeout is compiled in with `define TL_TIMEOUT_EN.
module tl_ul_master_engine #(
  parameter int SRC_SIZE       = 2,
  parameter int SINK_SIZE      = 2,
  parameter int BUS_SIZE       = 8,
  parameter int ADR_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [3:0]              cmd_size,
  input  logic [ADR_WIDTH-1:0]    cmd_addr,
  input  logic [BUS_SIZE-1:0]     cmd_mask,
  input  logic [8*BUS_SIZE-1:0]   cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [SRC_SIZE-1:0]     rsp_source,
  output logic [8*BUS_SIZE-1:0]   rsp_data,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic [SRC_SIZE:0]       outstanding,
  output logic                    err_unexp,
  input  logic                    a_ready,
  output logic                    a_valid,
  output logic [2:0]              a_bits_opcode,
  output logic [2:0]              a_bits_param,
  output logic [3:0]              a_bits_size,
  output logic [SRC_SIZE-1:0]     a_bits_source,
  output logic [ADR_WIDTH-1:0]    a_bits_address,
  output logic [BUS_SIZE-1:0]     a_bits_mask,
  output logic [8*BUS_SIZE-1:0]   a_bits_data,
  output logic                    a_bits_corrupt,
  output logic                    d_ready,
  input  logic                    d_valid,
  input  logic [2:0]              d_bits_opcode,
  input  logic [1:0]              d_bits_param,
  input  logic [3:0]              d_bits_size,
  input  logic [SRC_SIZE-1:0]     d_bits_source,
  input  logic [SINK_SIZE-1:0]    d_bits_sink,
  input  logic                    d_bits_denied,
  input  logic [8*BUS_SIZE-1:0]   d_bits_data,
  input  logic                    d_bits_corrupt
);

  localparam int NUM_ID  = 1 << SRC_SIZE;
  localparam int DW      = 8 * BUS_SIZE;
  localparam int LOG_BUS = $clog2(BUS_SIZE);
  localparam int OFF_W   = (LOG_BUS > 0) ? LOG_BUS : 1;
  localparam logic [3:0] MAX_SIZE = 4'(LOG_BUS);

  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  logic [NUM_ID-1:0]   busy_q, busy_d;
  logic                anyFree;
  logic [SRC_SIZE-1:0] freeId;
  logic                accept, rspFree, dFire, dKnown, dLoad, putFull;
  logic [BUS_SIZE-1:0] reqMask;
  logic [2:0]          cmdOpcode;
  int                  laneOff;
  logic                toFire;
  logic [SRC_SIZE-1:0] toId;
  logic                unusedBits;

  logic                 aValid_q;
  logic [2:0]           aOpcode_q;
  logic [3:0]           aSize_q;
  logic [SRC_SIZE-1:0]  aSource_q;
  logic [ADR_WIDTH-1:0] aAddress_q;
  logic [BUS_SIZE-1:0]  aMask_q;
  logic [DW-1:0]        aData_q;

  logic                 rspValid_q;
  logic [SRC_SIZE-1:0]  rspSource_q;
  logic [DW-1:0]        rspData_q;
  logic                 rspError_q;
  logic                 rspTimeout_q;
  logic                 errUnexp_q;

  always_comb begin
    anyFree = 1'b0;
    freeId  = '0;
    for (int i = NUM_ID - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        anyFree = 1'b1;
        freeId  = SRC_SIZE'(i);
      end
    end
  end

  assign cmd_ready = anyFree & (~aValid_q | a_ready);
  assign accept    = cmd_valid & cmd_ready;
  assign rspFree   = ~rspValid_q | rsp_ready;
  assign d_ready   = rspFree;
  assign dFire     = d_valid & d_ready;
  assign dKnown    = busy_q[d_bits_source];
  assign dLoad     = dFire & dKnown;

  // Lanes of the naturally aligned 2**size block that contains the command address.
  always_comb begin
    laneOff = int'(cmd_addr[OFF_W-1:0]) & (BUS_SIZE - 1);
    reqMask = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      reqMask[i] = ((i >> cmd_size) == (laneOff >> cmd_size));
    end
  end

  assign putFull   = ((cmd_mask & reqMask) == reqMask);
  assign cmdOpcode = !cmd_write ? OP_GET : (putFull ? OP_PUT_FULL : OP_PUT_PARTIAL);

`ifdef TL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q [NUM_ID];

  // A real D beat owns the response register this cycle; an expired ID simply waits.
  always_comb begin
    toFire = 1'b0;
    toId   = '0;
    for (int i = NUM_ID - 1; i >= 0; i--) begin
      if (busy_q[i] && (cnt_q[i] == CNT_MAX)) begin
        toFire = 1'b1;
        toId   = SRC_SIZE'(i);
      end
    end
    if (dLoad || !rspFree) toFire = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ID; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ID; i++) begin
        if (accept && (freeId == SRC_SIZE'(i))) begin
          cnt_q[i] <= CW'(1);
        end else if (busy_q[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign unusedBits = ^{d_bits_param, d_bits_size, d_bits_sink};
`else
  assign toFire     = 1'b0;
  assign toId       = '0;
  assign unusedBits = ^{d_bits_param, d_bits_size, d_bits_sink, (TIMEOUT_CYCLES != 0)};
`endif

  always_comb begin
    busy_d = busy_q;
    if (accept) busy_d[freeId] = 1'b1;
    if (dLoad)  busy_d[d_bits_source] = 1'b0;
    if (toFire) busy_d[toId] = 1'b0;
  end

  // A request is never overwritten while held: accept requires the A slot to be draining.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      aValid_q   <= 1'b0;
      aOpcode_q  <= '0;
      aSize_q    <= '0;
      aSource_q  <= '0;
      aAddress_q <= '0;
      aMask_q    <= '0;
      aData_q    <= '0;
    end else if (accept) begin
      aValid_q   <= 1'b1;
      aOpcode_q  <= cmdOpcode;
      aSize_q    <= cmd_size;
      aSource_q  <= freeId;
      aAddress_q <= cmd_addr;
      aMask_q    <= cmd_mask;
      aData_q    <= cmd_data;
    end else if (a_ready) begin
      aValid_q   <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q       <= '0;
      errUnexp_q   <= 1'b0;
      rspValid_q   <= 1'b0;
      rspSource_q  <= '0;
      rspData_q    <= '0;
      rspError_q   <= 1'b0;
      rspTimeout_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (dFire && !dKnown) errUnexp_q <= 1'b1;
      if (dLoad) begin
        rspValid_q   <= 1'b1;
        rspSource_q  <= d_bits_source;
        rspData_q    <= (d_bits_opcode == OP_ACK_DATA) ? d_bits_data : '0;
        rspError_q   <= d_bits_denied | d_bits_corrupt;
        rspTimeout_q <= 1'b0;
      end else if (toFire) begin
        rspValid_q   <= 1'b1;
        rspSource_q  <= toId;
        rspData_q    <= '0;
        rspError_q   <= 1'b1;
        rspTimeout_q <= 1'b1;
      end else if (rsp_ready) begin
        rspValid_q   <= 1'b0;
      end
    end
  end

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < NUM_ID; i++) begin
      outstanding = outstanding + (SRC_SIZE+1)'(busy_q[i]);
    end
  end

  assign a_valid        = aValid_q;
  assign a_bits_opcode  = aOpcode_q;
  assign a_bits_param   = 3'b000;
  assign a_bits_size    = aSize_q;
  assign a_bits_source  = aSource_q;
  assign a_bits_address = aAddress_q;
  assign a_bits_mask    = aMask_q;
  assign a_bits_data    = aData_q;
  assign a_bits_corrupt = 1'b0;

  assign rsp_valid   = rspValid_q;
  assign rsp_source  = rspSource_q;
  assign rsp_data    = rspData_q;
  assign rsp_error   = rspError_q;
  assign rsp_timeout = rspTimeout_q;
  assign err_unexp   = errUnexp_q;

  // Only single-beat transfers are supported.
  illegalSize: assert property (@(posedge clock) disable iff (!reset_n)
    (cmd_valid && cmd_ready) |-> (cmd_size <= MAX_SIZE));

endmodule

// File: tb/tb_tl_ul_master_engine.sv
// Directed scoreboard bench for tl_ul_master_engine; the timeout scenario runs only with TL_TIMEOUT_EN defined.
module tb_tl_ul_master_engine;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_size;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_mask;
  logic [63:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_source;
  logic [63:0] rsp_data;
  logic        rsp_error, rsp_timeout;
  logic [2:0]  outstanding;
  logic        err_unexp;
  logic        a_ready, a_valid;
  logic [2:0]  a_bits_opcode, a_bits_param;
  logic [3:0]  a_bits_size;
  logic [1:0]  a_bits_source;
  logic [31:0] a_bits_address;
  logic [7:0]  a_bits_mask;
  logic [63:0] a_bits_data;
  logic        a_bits_corrupt;
  logic        d_ready, d_valid;
  logic [2:0]  d_bits_opcode;
  logic [1:0]  d_bits_param;
  logic [3:0]  d_bits_size;
  logic [1:0]  d_bits_source;
  logic [1:0]  d_bits_sink;
  logic        d_bits_denied;
  logic [63:0] d_bits_data;
  logic        d_bits_corrupt;

  tl_ul_master_engine #(
    .SRC_SIZE(2), .SINK_SIZE(2), .BUS_SIZE(8), .ADR_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_size(cmd_size),
    .cmd_addr(cmd_addr), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_source(rsp_source), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .outstanding(outstanding), .err_unexp(err_unexp),
    .a_ready(a_ready), .a_valid(a_valid), .a_bits_opcode(a_bits_opcode), .a_bits_param(a_bits_param),
    .a_bits_size(a_bits_size), .a_bits_source(a_bits_source), .a_bits_address(a_bits_address),
    .a_bits_mask(a_bits_mask), .a_bits_data(a_bits_data), .a_bits_corrupt(a_bits_corrupt),
    .d_ready(d_ready), .d_valid(d_valid), .d_bits_opcode(d_bits_opcode), .d_bits_param(d_bits_param),
    .d_bits_size(d_bits_size), .d_bits_source(d_bits_source), .d_bits_sink(d_bits_sink),
    .d_bits_denied(d_bits_denied), .d_bits_data(d_bits_data), .d_bits_corrupt(d_bits_corrupt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [1:0]  src;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        chkData;
  } aExp_t;

  typedef struct {
    logic [1:0]  src;
    logic [63:0] data;
    logic        err;
    logic        tmo;
  } rspExp_t;

  aExp_t   aExpQ[$];
  rspExp_t rspExpQ[$];
  aExp_t   aSeen;
  rspExp_t rspSeen;
  int      assertCount = 0;
  int      failCount   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every A and response handshake is matched against the next queued expectation.
  always @(negedge clock) begin
    if (reset_n && a_valid && a_ready) begin
      if (aExpQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL a_unexpected: A beat with source %0d, expected none", a_bits_source);
      end else begin
        aSeen = aExpQ.pop_front();
        checkOutput("a_opcode", 64'(a_bits_opcode), 64'(aSeen.op));
        checkOutput("a_source", 64'(a_bits_source), 64'(aSeen.src));
        checkOutput("a_size", 64'(a_bits_size), 64'(aSeen.size));
        checkOutput("a_address", 64'(a_bits_address), 64'(aSeen.addr));
        checkOutput("a_mask", 64'(a_bits_mask), 64'(aSeen.mask));
        checkOutput("a_param", 64'(a_bits_param), 64'd0);
        checkOutput("a_corrupt", 64'(a_bits_corrupt), 64'd0);
        if (aSeen.chkData) checkOutput("a_data", a_bits_data, aSeen.data);
      end
    end
    if (reset_n && rsp_valid && rsp_ready) begin
      if (rspExpQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL rsp_unexpected: response with source %0d, expected none", rsp_source);
      end else begin
        rspSeen = rspExpQ.pop_front();
        checkOutput("rsp_source", 64'(rsp_source), 64'(rspSeen.src));
        checkOutput("rsp_data", rsp_data, rspSeen.data);
        checkOutput("rsp_error", 64'(rsp_error), 64'(rspSeen.err));
        checkOutput("rsp_timeout", 64'(rsp_timeout), 64'(rspSeen.tmo));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expectRsp(input logic [1:0] src, input logic [63:0] data, input logic err, input logic tmo);
    rspExp_t e;
    e.src = src; e.data = data; e.err = err; e.tmo = tmo;
    rspExpQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic wr, input logic [3:0] sz, input logic [31:0] adr,
                               input logic [7:0] msk, input logic [63:0] dat,
                               input logic [2:0] expOp, input logic [1:0] expSrc);
    int waitCnt;
    aExp_t e;
    e.op = expOp; e.size = sz; e.src = expSrc; e.addr = adr; e.mask = msk; e.data = dat; e.chkData = wr;
    aExpQ.push_back(e);
    cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_addr = adr; cmd_mask = msk; cmd_data = dat;
    waitCnt = 0;
    @(negedge clock);
    while (!cmd_ready && waitCnt < 40) begin
      @(negedge clock);
      waitCnt++;
    end
    if (!cmd_ready) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL cmd_accept: cmd_ready stayed 0, expected 1 within 40 cycles");
      void'(aExpQ.pop_back());
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic sendD(input logic [2:0] op, input logic [1:0] src, input logic [63:0] dat,
                       input logic den, input logic cor);
    int waitCnt;
    d_valid = 1'b1; d_bits_opcode = op; d_bits_source = src; d_bits_data = dat;
    d_bits_denied = den; d_bits_corrupt = cor; d_bits_param = 2'd0; d_bits_size = 4'd3; d_bits_sink = 2'd1;
    waitCnt = 0;
    @(negedge clock);
    while (!d_ready && waitCnt < 40) begin
      @(negedge clock);
      waitCnt++;
    end
    if (!d_ready) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL d_accept: d_ready stayed 0, expected 1 within 40 cycles");
    end
    @(posedge clock);
    #1;
    d_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 4'd0; cmd_addr = 32'd0; cmd_mask = 8'd0; cmd_data = 64'd0;
    rsp_ready = 1'b1; a_ready = 1'b1;
    d_valid = 1'b0; d_bits_opcode = 3'd0; d_bits_param = 2'd0; d_bits_size = 4'd0; d_bits_source = 2'd0;
    d_bits_sink = 2'd0; d_bits_denied = 1'b0; d_bits_data = 64'd0; d_bits_corrupt = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_a_valid", 64'(a_valid), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_err_unexp", 64'(err_unexp), 64'd0);
    checkOutput("reset_outstanding", 64'(outstanding), 64'd0);
    checkOutput("reset_d_ready", 64'(d_ready), 64'd1);
    checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("reset_a_opcode", 64'(a_bits_opcode), 64'd0);
    checkOutput("reset_a_address", 64'(a_bits_address), 64'd0);
    checkOutput("reset_rsp_data", rsp_data, 64'd0);
    checkOutput("reset_rsp_timeout", 64'(rsp_timeout), 64'd0);
    reset_n = 1'b1;
    tick(1);

    $display("[TB] Get with AccessAckData");
    applyStimulus(1'b0, 4'd3, 32'h8000_0000, 8'hFF, 64'd0, 3'd4, 2'd0);
    checkOutput("get_outstanding", 64'(outstanding), 64'd1);
    checkOutput("get_a_valid", 64'(a_valid), 64'd1);
    expectRsp(2'd0, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
    sendD(3'd1, 2'd0, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
    tick(2);
    checkOutput("get_outstanding_done", 64'(outstanding), 64'd0);

    $display("[TB] Four back-to-back writes fill the ID map");
    applyStimulus(1'b1, 4'd3, 32'h0000_0100, 8'hFF, 64'h1111_0000_0000_0001, 3'd0, 2'd0);
    applyStimulus(1'b1, 4'd3, 32'h0000_0108, 8'hFF, 64'h2222_0000_0000_0002, 3'd0, 2'd1);
    applyStimulus(1'b1, 4'd3, 32'h0000_0110, 8'hFF, 64'h3333_0000_0000_0003, 3'd0, 2'd2);
    applyStimulus(1'b1, 4'd3, 32'h0000_0118, 8'hFF, 64'h4444_0000_0000_0004, 3'd0, 2'd3);
    checkOutput("full_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("full_outstanding", 64'(outstanding), 64'd4);
    expectRsp(2'd2, 64'd0, 1'b0, 1'b0);
    sendD(3'd0, 2'd2, 64'h5555_5555_5555_5555, 1'b0, 1'b0);
    checkOutput("freed_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("freed_outstanding", 64'(outstanding), 64'd3);
    applyStimulus(1'b1, 4'd3, 32'h0000_0200, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 3'd1, 2'd2);
    expectRsp(2'd0, 64'd0, 1'b1, 1'b0);
    sendD(3'd0, 2'd0, 64'd0, 1'b1, 1'b0);
    expectRsp(2'd1, 64'd0, 1'b1, 1'b0);
    sendD(3'd0, 2'd1, 64'd0, 1'b0, 1'b1);
    expectRsp(2'd3, 64'd0, 1'b0, 1'b0);
    sendD(3'd0, 2'd3, 64'h1234, 1'b0, 1'b0);
    expectRsp(2'd2, 64'd0, 1'b0, 1'b0);
    sendD(3'd0, 2'd2, 64'd0, 1'b0, 1'b0);
    tick(2);
    checkOutput("drained_outstanding", 64'(outstanding), 64'd0);

    $display("[TB] Sub-word masks");
    applyStimulus(1'b1, 4'd2, 32'h0000_0204, 8'hF0, 64'h0102_0304_0000_0000, 3'd0, 2'd0);
    applyStimulus(1'b1, 4'd2, 32'h0000_0204, 8'h30, 64'h0000_0304_0000_0000, 3'd1, 2'd1);
    applyStimulus(1'b0, 4'd0, 32'h0000_0003, 8'h08, 64'd0, 3'd4, 2'd2);
    expectRsp(2'd0, 64'd0, 1'b0, 1'b0);
    sendD(3'd0, 2'd0, 64'd0, 1'b0, 1'b0);
    expectRsp(2'd1, 64'd0, 1'b0, 1'b0);
    sendD(3'd0, 2'd1, 64'd0, 1'b0, 1'b0);
    expectRsp(2'd2, 64'h0000_0000_AB00_0000, 1'b0, 1'b0);
    sendD(3'd1, 2'd2, 64'h0000_0000_AB00_0000, 1'b0, 1'b0);
    tick(2);

    $display("[TB] A-channel backpressure");
    a_ready = 1'b0;
    applyStimulus(1'b1, 4'd3, 32'h0000_0400, 8'hFF, 64'hCAFE_F00D_1234_5678, 3'd0, 2'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checkOutput("stall_a_valid", 64'(a_valid), 64'd1);
      checkOutput("stall_a_address", 64'(a_bits_address), 64'h400);
      checkOutput("stall_a_data", a_bits_data, 64'hCAFE_F00D_1234_5678);
      checkOutput("stall_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    @(posedge clock);
    #1;
    a_ready = 1'b1;

    $display("[TB] Response backpressure");
    applyStimulus(1'b0, 4'd3, 32'h0000_0500, 8'hFF, 64'd0, 3'd4, 2'd1);
    rsp_ready = 1'b0;
    expectRsp(2'd0, 64'd0, 1'b0, 1'b0);
    sendD(3'd0, 2'd0, 64'd0, 1'b0, 1'b0);
    expectRsp(2'd1, 64'h1122_3344_5566_7788, 1'b0, 1'b0);
    d_valid = 1'b1; d_bits_opcode = 3'd1; d_bits_source = 2'd1; d_bits_data = 64'h1122_3344_5566_7788;
    d_bits_denied = 1'b0; d_bits_corrupt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput("hold_d_ready", 64'(d_ready), 64'd0);
      checkOutput("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("hold_rsp_source", 64'(rsp_source), 64'd0);
    end
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    d_valid = 1'b0;
    tick(2);
    checkOutput("hold_outstanding", 64'(outstanding), 64'd0);

    $display("[TB] D beat for an idle source");
    sendD(3'd1, 2'd3, 64'h99, 1'b0, 1'b0);
    checkOutput("unexp_err", 64'(err_unexp), 64'd1);
    @(negedge clock);
    checkOutput("unexp_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("unexp_outstanding", 64'(outstanding), 64'd0);
    tick(1);

    $display("[TB] Reset in the middle of a burst");
    applyStimulus(1'b1, 4'd3, 32'h0000_0700, 8'hFF, 64'h7000, 3'd0, 2'd0);
    applyStimulus(1'b1, 4'd3, 32'h0000_0708, 8'hFF, 64'h7008, 3'd0, 2'd1);
    tick(1);
    a_ready = 1'b0;
    applyStimulus(1'b1, 4'd3, 32'h0000_0720, 8'hFF, 64'h7020, 3'd0, 2'd2);
    checkOutput("burst_outstanding", 64'(outstanding), 64'd3);
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    aExpQ.delete();
    rspExpQ.delete();
    #2;
    checkOutput("midrst_a_valid", 64'(a_valid), 64'd0);
    checkOutput("midrst_a_address", 64'(a_bits_address), 64'd0);
    checkOutput("midrst_a_source", 64'(a_bits_source), 64'd0);
    checkOutput("midrst_outstanding", 64'(outstanding), 64'd0);
    checkOutput("midrst_err_unexp", 64'(err_unexp), 64'd0);
    checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midrst_d_ready", 64'(d_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    a_ready = 1'b1;
    tick(1);
    applyStimulus(1'b0, 4'd3, 32'h0000_0800, 8'hFF, 64'd0, 3'd4, 2'd0);
    expectRsp(2'd0, 64'h7, 1'b0, 1'b0);
    sendD(3'd1, 2'd0, 64'h7, 1'b0, 1'b0);
    tick(2);

`ifdef TL_TIMEOUT_EN
    $display("[TB] Response timeout");
    applyStimulus(1'b0, 4'd3, 32'h0000_0900, 8'hFF, 64'd0, 3'd4, 2'd0);
    expectRsp(2'd0, 64'd0, 1'b1, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (k == 15) checkOutput("tmo_early_rsp_valid", 64'(rsp_valid), 64'd0);
      if (k == 16) begin
        checkOutput("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("tmo_rsp_timeout", 64'(rsp_timeout), 64'd1);
        checkOutput("tmo_outstanding", 64'(outstanding), 64'd0);
      end
    end
    tick(1);
    sendD(3'd1, 2'd0, 64'h1, 1'b0, 1'b0);
    checkOutput("tmo_late_d_err_unexp", 64'(err_unexp), 64'd1);
`endif

    tick(3);
    checkOutput("a_queue_drained", 64'(aExpQ.size()), 64'd0);
    checkOutput("rsp_queue_drained", 64'(rspExpQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
